color_ctrl: RTL and testbench

COLOR_CTRL -- requirements
Module: color_ctrl

---
 rtl/color_ctrl.sv | 135 +++++++++++++
 tb/tb_color_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/color_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : color_ctrl
// Purpose  : Debounced button steps FIXED/SWITCH/CYCLE colour modes; drives a
//            registered 12-bit RGB colour.
// Revision : 1.0  initial release
// ============================================================================
module color_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          CYCLE_TICKS     = 25000000,
    parameter logic [11:0] RESET_COLOR     = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic [15:0] sw,
    output logic [11:0] col,
    output logic [1:0]  mode,
    output logic        press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = (CYCLE_TICKS > 1) ? $clog2(CYCLE_TICKS) : 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CYCLE_TICKS - 1);

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_SWITCH = 2'd1,
        MODE_CYCLE  = 2'd2
    } mode_t;

    logic          btn_m, btn_s;
    logic [11:0]   sw_m, sw_s;
    logic          btn_d, btn_d_q;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] tick, tick_nx;
    logic [2:0]    idx, idx_nx;
    logic [11:0]   col_nx;
    logic          rise;
    mode_t         mode_q, mode_nx;

    function automatic logic [11:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    palette = 12'hF00;
            3'd1:    palette = 12'hFF0;
            3'd2:    palette = 12'h0F0;
            3'd3:    palette = 12'h0FF;
            3'd4:    palette = 12'h00F;
            default: palette = 12'hF0F;
        endcase
    endfunction

    // Two-flop synchronizers for the asynchronous inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= 12'h000;
            sw_s  <= 12'h000;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            sw_m  <= sw[11:0];
            sw_s  <= sw_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_d   <= 1'b0;
            btn_d_q <= 1'b0;
            deb_cnt <= '0;
        end else begin
            btn_d_q <= btn_d;
            if (btn_s == btn_d) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_d   <= ~btn_d;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign rise = btn_d & ~btn_d_q;

    always_comb begin
        mode_nx = mode_q;
        tick_nx = '0;
        idx_nx  = 3'd0;
        col_nx  = RESET_COLOR;
        if (rise) begin
            // A press wins over a simultaneous tick wrap
            case (mode_q)
                MODE_FIXED:  mode_nx = MODE_SWITCH;
                MODE_SWITCH: mode_nx = MODE_CYCLE;
                default:     mode_nx = MODE_FIXED;
            endcase
        end else if (mode_q == MODE_CYCLE) begin
            if (tick == TICK_LAST) begin
                idx_nx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                tick_nx = tick + TW'(1);
                idx_nx  = idx;
            end
        end
        case (mode_nx)
            MODE_SWITCH: col_nx = sw_s;
            MODE_CYCLE:  col_nx = palette(idx_nx);
            default:     col_nx = RESET_COLOR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_FIXED;
            tick   <= '0;
            idx    <= 3'd0;
            col    <= RESET_COLOR;
            press  <= 1'b0;
        end else begin
            mode_q <= mode_nx;
            tick   <= tick_nx;
            idx    <= idx_nx;
            col    <= col_nx;
            press  <= rise;
        end
    end

    assign mode = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_color_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_ctrl
// Purpose  : Directed self-checking bench for color_ctrl with a cycle model.
// Revision : 1.0  initial release
// ============================================================================
module tb_color_ctrl;

    localparam int DEB   = 4;
    localparam int TICKS = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn = 1'b0;
    logic [15:0] sw  = 16'h0000;
    logic [11:0] col;
    logic [1:0]  mode;
    logic        press;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    color_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CYCLE_TICKS    (TICKS),
        .RESET_COLOR    (12'h0F0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .sw   (sw),
        .col  (col),
        .mode (mode),
        .press(press)
    );

    always #5 clk = ~clk;

    logic [11:0] pal [6] = '{12'hF00, 12'hFF0, 12'h0F0, 12'h0FF, 12'h00F, 12'hF0F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: btn/sw seen two edges late, debounced level flips after DEB
    // consecutive disagreeing samples, press one cycle after the flip to 1,
    // mode = presses mod 3, CYCLE colour from time elapsed since entry.
    logic        m_b0, m_b1, m_bd, m_pend;
    logic [11:0] m_s0, m_s1;
    int          m_run, m_cyc, m_enter;
    logic [1:0]  m_mode;
    logic [11:0] m_col;
    logic        m_press;

    always @(posedge clk or posedge rst) begin
        logic        old_bs;
        logic [11:0] old_sw;
        if (rst) begin
            m_b0 = 0; m_b1 = 0; m_bd = 0; m_pend = 0;
            m_s0 = 0; m_s1 = 0; m_run = 0; m_cyc = 0; m_enter = 0;
            m_mode = 0; m_col = 12'h0F0; m_press = 0;
        end else begin
            old_bs = m_b1;
            old_sw = m_s1;
            m_b1 = m_b0; m_b0 = btn;
            m_s1 = m_s0; m_s0 = sw[11:0];
            m_press = m_pend;
            m_pend  = 0;
            m_run = (old_bs != m_bd) ? m_run + 1 : 0;
            if (m_run == DEB) begin
                m_bd  = ~m_bd;
                m_run = 0;
                m_pend = m_bd;
            end
            if (m_press) begin
                m_mode = (m_mode == 2) ? 2'd0 : m_mode + 2'd1;
                if (m_mode == 2) m_enter = m_cyc;
            end
            case (m_mode)
                2'd1:    m_col = old_sw;
                2'd2:    m_col = pal[((m_cyc - m_enter) / TICKS) % 6];
                default: m_col = 12'h0F0;
            endcase
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_col",   32'(col),   32'(m_col));
            check("model_mode",  32'(mode),  32'(m_mode));
            check("model_press", 32'(press), 32'(m_press));
        end
    end

    task automatic run(input int n, inout int p);
        repeat (n) begin
            @(negedge clk);
            if (press) p++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p;
        bit  found;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_col",   32'(col),   32'h0F0);
        check("reset_mode",  32'(mode),  32'd0);
        check("reset_press", 32'(press), 32'd0);
        rst = 1'b0;
        p = 0;
        run(5, p);
        check("idle_no_press", p, 0);

        // Clean press held 20 cycles, then release
        btn = 1'b1;
        run(20, p);
        check("clean_press_count", p, 1);
        check("clean_mode", 32'(mode), 32'd1);
        btn = 1'b0;
        run(10, p);
        check("release_no_press", p, 1);
        check("release_mode", 32'(mode), 32'd1);

        // SWITCH mode latency and ignored upper bits
        sw = 16'hFABC;
        run(2, p);
        check("sw_lat2_old", 32'(col), 32'h000);
        run(1, p);
        check("sw_lat3_new", 32'(col), 32'hABC);
        sw = 16'h0ABC;
        run(5, p);
        check("sw_upper_ignored", 32'(col), 32'hABC);
        sw = 16'h1234;
        run(3, p);
        check("sw_second", 32'(col), 32'h234);

        // Bounce then settle high
        p = 0;
        btn = 1'b1; run(3, p);
        btn = 1'b0; run(3, p);
        btn = 1'b1; run(3, p);
        btn = 1'b0; run(3, p);
        check("bounce_no_press", p, 0);
        btn = 1'b1;
        run(12, p);
        check("bounce_settle_press", p, 1);
        check("bounce_mode", 32'(mode), 32'd2);

        // Asynchronous reset mid-run in CYCLE mode, btn held through it
        #2 rst = 1'b1;
        #1;
        check("async_rst_col",   32'(col),   32'h0F0);
        check("async_rst_mode",  32'(mode),  32'd0);
        check("async_rst_press", 32'(press), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        p = 0;
        run(15, p);
        check("held_rst_press", p, 1);
        check("held_rst_mode", 32'(mode), 32'd1);

        // Second press into CYCLE mode, then walk the palette
        btn = 1'b0;
        run(10, p);
        btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (press) found = 1'b1;
        end
        check("cycle_press_seen", 32'(found), 32'd1);
        check("cycle_entry_mode", 32'(mode), 32'd2);
        for (int k = 0; k <= 48; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) btn = 1'b0;
            check($sformatf("palette_k%0d", k), 32'(col), 32'(pal[(k / 8) % 6]));
        end

        // Press timed to land on the tick wrap at k=56
        @(negedge clk);
        btn = 1'b1;
        repeat (6) @(negedge clk);
        check("collide_pre_col",  32'(col),  32'hF00);
        check("collide_pre_mode", 32'(mode), 32'd2);
        @(negedge clk);
        check("collide_mode",  32'(mode),  32'd0);
        check("collide_col",   32'(col),   32'h0F0);
        check("collide_press", 32'(press), 32'd1);
        btn = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
